// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings and the MEM/WB field bundle.
// The link fields exist only when WB_LINK_EN is defined.
package mips_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [1:0] LD_BYTE = 2'b00;
   localparam logic [1:0] LD_HALF = 2'b01;
   localparam logic [1:0] LD_WORD = 2'b10;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic              reg_write;
      logic              mem_to_reg;
      logic [1:0]        load_size;
      logic              load_unsigned;
      logic [1:0]        byte_offset;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] read_data;
      logic [ADDR_W-1:0] write_address;
`ifdef WB_LINK_EN
      logic              link;
      logic [DATA_W-1:0] pc_plus8;
`endif
   } wb_fields_t;
endpackage

// File: rtl/wb_load_align.sv
// Combinational load lane select and sign/zero extension.
// Memory words are big-endian: byte offset 0 is bits [31:24].
module wb_load_align
   import mips_pkg::*;
(
   input  logic [DATA_W-1:0] raw_i,
   input  logic [1:0]        size_i,
   input  logic [1:0]        offset_i,
   input  logic              unsigned_i,
   output logic [DATA_W-1:0] value_o
);
   logic [3:0][7:0]  lanes;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;

   assign lanes    = raw_i;
   // Packed lane 3 holds offset 0, so the lane index is the inverted offset.
   assign byte_sel = lanes[~offset_i];
   assign half_sel = offset_i[1] ? raw_i[15:0] : raw_i[31:16];

   always_comb begin
      value_o = raw_i;
      case (size_i)
         LD_BYTE: value_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         LD_HALF: value_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         LD_WORD: value_o = raw_i;
         default: value_o = raw_i;
      endcase
   end
endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and write-back mux driving the register-file write port.
// Optional JAL/JALR link path enabled by defining WB_LINK_EN.
module mem_wb_writeback #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall_in,
   input  logic              flush_in,
   input  logic              mem_valid,
   input  logic              mem_reg_write,
   input  logic              mem_mem_to_reg,
   input  logic [1:0]        mem_load_size,
   input  logic              mem_load_unsigned,
   input  logic [1:0]        mem_byte_offset,
   input  logic [DATA_W-1:0] mem_alu_result,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic [ADDR_W-1:0] mem_write_address,
`ifdef WB_LINK_EN
   input  logic              mem_link,
   input  logic [DATA_W-1:0] mem_pc_plus8,
`endif
   output logic [ADDR_W-1:0] reg_write_address,
   output logic [DATA_W-1:0] data,
   output logic              ctrl_reg_write,
   output logic              wb_fwd_valid,
   output logic [CNT_W-1:0]  retired_count
);
   import mips_pkg::*;

   wb_fields_t       wb_q, wb_d;
   logic             wb_valid_q, wb_valid_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [31:0]      load_val;

   always_comb begin
      wb_d       = wb_q;
      wb_valid_d = wb_valid_q;
      retired_d  = retired_q;
      // The instruction already in WB retires on any unstalled edge, flush or not.
      if (wb_valid_q && !stall_in) retired_d = retired_q + CNT_W'(1);
      if (flush_in) begin
         wb_valid_d = 1'b0;
      end else if (!stall_in) begin
         wb_valid_d            = mem_valid;
         wb_d.reg_write        = mem_reg_write;
         wb_d.mem_to_reg       = mem_mem_to_reg;
         wb_d.load_size        = mem_load_size;
         wb_d.load_unsigned    = mem_load_unsigned;
         wb_d.byte_offset      = mem_byte_offset;
         wb_d.alu_result       = mem_alu_result;
         wb_d.read_data        = mem_read_data;
         wb_d.write_address    = mem_write_address;
`ifdef WB_LINK_EN
         wb_d.link             = mem_link;
         wb_d.pc_plus8         = mem_pc_plus8;
`endif
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wb_q       <= '0;
         wb_valid_q <= 1'b0;
         retired_q  <= '0;
      end else begin
         wb_q       <= wb_d;
         wb_valid_q <= wb_valid_d;
         retired_q  <= retired_d;
      end
   end

   wb_load_align u_align (
      .raw_i      (wb_q.read_data),
      .size_i     (wb_q.load_size),
      .offset_i   (wb_q.byte_offset),
      .unsigned_i (wb_q.load_unsigned),
      .value_o    (load_val)
   );

   always_comb begin
      data = wb_q.mem_to_reg ? load_val : wb_q.alu_result;
`ifdef WB_LINK_EN
      if (wb_q.link) data = wb_q.pc_plus8;
`endif
   end

   assign reg_write_address = wb_q.write_address;
   assign ctrl_reg_write    = wb_valid_q & wb_q.reg_write & (wb_q.write_address != REG_ZERO);
   assign wb_fwd_valid      = ctrl_reg_write;
   assign retired_count     = retired_q;
endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed vector bench for mem_wb_writeback; a narrow-counter instance checks wrap.
// Link cases run only when WB_LINK_EN is defined.
module tb_mem_wb_writeback;
   logic        clock = 1'b0;
   logic        reset, stall_in, flush_in;
   logic        mem_valid, mem_reg_write, mem_mem_to_reg, mem_load_unsigned;
   logic [1:0]  mem_load_size, mem_byte_offset;
   logic [31:0] mem_alu_result, mem_read_data;
   logic [4:0]  mem_write_address;
`ifdef WB_LINK_EN
   logic        mem_link;
   logic [31:0] mem_pc_plus8;
`endif
   logic [4:0]  reg_write_address, w_addr;
   logic [31:0] data, w_data;
   logic        ctrl_reg_write, wb_fwd_valid, w_we, w_fwd;
   logic [31:0] retired_count;
   logic [2:0]  w_count;

   int pass_cnt = 0, total_cnt = 0;
   int model_cnt = 0;
   logic model_valid = 1'b0;

   always #5 clock = ~clock;

   mem_wb_writeback dut (
      .clock(clock), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_load_size(mem_load_size), .mem_load_unsigned(mem_load_unsigned),
      .mem_byte_offset(mem_byte_offset), .mem_alu_result(mem_alu_result),
      .mem_read_data(mem_read_data), .mem_write_address(mem_write_address),
`ifdef WB_LINK_EN
      .mem_link(mem_link), .mem_pc_plus8(mem_pc_plus8),
`endif
      .reg_write_address(reg_write_address), .data(data), .ctrl_reg_write(ctrl_reg_write),
      .wb_fwd_valid(wb_fwd_valid), .retired_count(retired_count)
   );

   mem_wb_writeback #(.CNT_W(3)) dut_w (
      .clock(clock), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_load_size(mem_load_size), .mem_load_unsigned(mem_load_unsigned),
      .mem_byte_offset(mem_byte_offset), .mem_alu_result(mem_alu_result),
      .mem_read_data(mem_read_data), .mem_write_address(mem_write_address),
`ifdef WB_LINK_EN
      .mem_link(mem_link), .mem_pc_plus8(mem_pc_plus8),
`endif
      .reg_write_address(w_addr), .data(w_data), .ctrl_reg_write(w_we),
      .wb_fwd_valid(w_fwd), .retired_count(w_count)
   );

   typedef struct {
      logic        valid, rw, m2r;
      logic [1:0]  size;
      logic        uns;
      logic [1:0]  off;
      logic [31:0] alu, rd;
      logic [4:0]  addr;
      logic [31:0] e_data;
      logic [4:0]  e_addr;
      logic        e_we;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive(input vec_t v);
      mem_valid = v.valid; mem_reg_write = v.rw; mem_mem_to_reg = v.m2r;
      mem_load_size = v.size; mem_load_unsigned = v.uns; mem_byte_offset = v.off;
      mem_alu_result = v.alu; mem_read_data = v.rd; mem_write_address = v.addr;
   endtask

   // One clock edge with a reference model of valid and retired count.
   task automatic step();
      @(posedge clock);
      if (model_valid && !stall_in && !reset) model_cnt++;
      if (reset || flush_in) model_valid = 1'b0;
      else if (!stall_in) model_valid = mem_valid;
      @(negedge clock);
   endtask

   task automatic chk_out(input string nm, input logic [31:0] e_data, input logic [4:0] e_addr,
                          input logic e_we);
      chk({nm, ".data"}, data, e_data);
      chk({nm, ".addr"}, 32'(reg_write_address), 32'(e_addr));
      chk({nm, ".we"}, 32'(ctrl_reg_write), 32'(e_we));
      chk({nm, ".fwd"}, 32'(wb_fwd_valid), 32'(e_we));
   endtask

   task automatic chk_cnt(input string nm);
      chk({nm, ".cnt"}, retired_count, 32'(model_cnt));
      chk({nm, ".cnt3"}, 32'(w_count), 32'(model_cnt % 8));
   endtask

   initial begin
      vec_t v;
      // valid rw m2r size uns off alu rd addr | data addr we
      vecs[0]  = '{1, 1, 1, 2'b00, 0, 2'd1, 32'h0, 32'h12F45678, 5'd8,  32'hFFFFFFF4, 5'd8,  1};
      vecs[1]  = '{1, 1, 1, 2'b00, 1, 2'd1, 32'h0, 32'h12F45678, 5'd8,  32'h000000F4, 5'd8,  1};
      vecs[2]  = '{1, 1, 1, 2'b01, 0, 2'd2, 32'h0, 32'h00008001, 5'd9,  32'hFFFF8001, 5'd9,  1};
      vecs[3]  = '{1, 1, 1, 2'b10, 0, 2'd3, 32'h0, 32'hDEADBEEF, 5'd10, 32'hDEADBEEF, 5'd10, 1};
      vecs[4]  = '{1, 1, 0, 2'b10, 0, 2'd0, 32'h5, 32'h0,        5'd0,  32'h00000005, 5'd0,  0};
      vecs[5]  = '{1, 1, 0, 2'b00, 0, 2'd2, 32'h1234, 32'hFFFFFFFF, 5'd3, 32'h00001234, 5'd3, 1};
      vecs[6]  = '{1, 1, 1, 2'b01, 1, 2'd0, 32'h0, 32'h80017FFF, 5'd4,  32'h00008001, 5'd4,  1};
      vecs[7]  = '{1, 1, 1, 2'b00, 0, 2'd3, 32'h0, 32'h0000007F, 5'd5,  32'h0000007F, 5'd5,  1};
      vecs[8]  = '{1, 1, 1, 2'b01, 0, 2'd1, 32'h0, 32'hABCD1234, 5'd6,  32'hFFFFABCD, 5'd6,  1};
      vecs[9]  = '{1, 0, 0, 2'b00, 0, 2'd0, 32'h77, 32'h0,       5'd4,  32'h00000077, 5'd4,  0};
      vecs[10] = '{0, 1, 0, 2'b00, 0, 2'd0, 32'h99, 32'h0,       5'd5,  32'h00000099, 5'd5,  0};
      vecs[11] = '{1, 1, 1, 2'b11, 0, 2'd1, 32'h0, 32'hCAFEF00D, 5'd7,  32'hCAFEF00D, 5'd7,  1};

      reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
      drive(vecs[0]);
`ifdef WB_LINK_EN
      mem_link = 1'b0; mem_pc_plus8 = 32'h0;
`endif
      repeat (2) @(negedge clock);
      chk_out("reset", 32'h0, 5'd0, 1'b0);
      chk_cnt("reset");
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i]);
         step();
         chk_out($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_addr, vecs[i].e_we);
         chk_cnt($sformatf("vec%0d", i));
      end

      // Stall holds WB contents while MEM inputs change underneath.
      v = vecs[5]; drive(v); step();
      stall_in = 1'b1;
      drive(vecs[2]);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out($sformatf("stall%0d", i), 32'h00001234, 5'd3, 1'b1);
         chk_cnt($sformatf("stall%0d", i));
      end
      stall_in = 1'b0; step();
      chk_out("release", 32'hFFFF8001, 5'd9, 1'b1);
      chk_cnt("release");

      // Flush and stall together: WB empties, nothing retires.
      stall_in = 1'b1; flush_in = 1'b1; step();
      chk("flushstall.we", 32'(ctrl_reg_write), 32'd0);
      chk_cnt("flushstall");
      // Plain flush of a valid WB entry still retires it.
      stall_in = 1'b0; flush_in = 1'b0; drive(vecs[3]); step();
      flush_in = 1'b1; step();
      flush_in = 1'b0;
      chk("flush.we", 32'(ctrl_reg_write), 32'd0);
      chk_cnt("flush");

      // Asynchronous reset between edges while stalled.
      drive(vecs[6]); step();
      stall_in = 1'b1;
      #2 reset = 1'b1; model_cnt = 0; model_valid = 1'b0;
      #1 chk_out("asyncrst", 32'h0, 5'd0, 1'b0);
      chk_cnt("asyncrst");
      @(negedge clock); reset = 1'b0; stall_in = 1'b0;

      // Nine retirements wrap the 3-bit counter back to 1.
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i % 4]); step();
      end
      drive(vecs[10]); step();
      chk_cnt("wrap");
      chk("wrap.narrow", 32'(w_count), 32'd1);

`ifdef WB_LINK_EN
      v = vecs[0]; v.addr = 5'd31; v.alu = 32'h55;
      drive(v); mem_link = 1'b1; mem_pc_plus8 = 32'h00400010; step();
      chk_out("jal", 32'h00400010, 5'd31, 1'b1);
      v.rw = 1'b0; drive(v); step();
      chk_out("jal_norw", 32'h00400010, 5'd31, 1'b0);
      mem_link = 1'b0;
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
